conv_mac_pipe: RTL

Pipelined, parametrised convolution multiply-accumulate engine: one KSIZE×KSIZE pixel window plus a stored signed kernel in, one rounded, saturated output pixel out. It generalises the single-cycle slice ALU with:
- configurable window size and operand widths;
- a loadable kernel register;
- a programmable output shift with rounding;
- valid/ready handshaking on both sides.

It sits between the line-buffer/window generator (upstream) and the output frame writer (downstream).

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_adder_tree.sv | 21 ++
 rtl/conv_mac_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution MAC engine.
package conv_pkg;

  localparam int unsigned DWIDTH_DAT = 8;
  localparam int unsigned KSIZE      = 3;
  localparam int unsigned KWIDTH     = 4;
  localparam int unsigned SHIFT      = 4;

  // Ceiling log2 for elaboration-time width arithmetic.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed value into the two's-complement range of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Combinational signed reduction of N packed products; isolated so a pipelined tree can drop in.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int unsigned N  = 9,
  parameter int unsigned PW = 13
) (
  input  logic [N*PW-1:0]                 prods,
  output logic signed [PW+clog2(N)-1:0]   sum_c
);

  localparam int unsigned SW = PW + clog2(N);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      sum_c = sum_c + SW'($signed(prods[i*PW +: PW]));
    end
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Three-stage convolution MAC (multiply, sum, round/saturate) with valid/ready on both sides.
// Define CONV_MAC_RELU_EN to clamp negative results to zero before saturation.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int unsigned DWIDTH_DAT = conv_pkg::DWIDTH_DAT,
  parameter int unsigned KSIZE      = conv_pkg::KSIZE,
  parameter int unsigned KWIDTH     = conv_pkg::KWIDTH,
  parameter int unsigned SHIFT      = conv_pkg::SHIFT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 k_load,
  input  logic [KSIZE*KSIZE*KWIDTH-1:0]        k_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [KSIZE*KSIZE*DWIDTH_DAT-1:0]    din,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DWIDTH_DAT-1:0]                dout
);

  localparam int unsigned N    = KSIZE * KSIZE;
  localparam int unsigned DW   = DWIDTH_DAT;
  localparam int unsigned PW   = DWIDTH_DAT + KWIDTH + 1;
  localparam int unsigned LOGN = clog2(N);
  localparam int unsigned SW   = PW + LOGN;
  localparam int unsigned AW   = SW + 1;
  localparam int unsigned RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW-1:0] RND = (SHIFT > 0) ? (AW'(1) << RSH) : '0;

  logic [N*KWIDTH-1:0]    kernel;
  logic                   s1_valid;
  logic [N*PW-1:0]        s1_prod;
  logic                   s2_valid;
  logic signed [SW-1:0]   s2_sum;

  logic                   ld1_c;
  logic                   ld2_c;
  logic                   ld3_c;
  logic                   in_acc_c;
  logic [N*PW-1:0]        prod_c;
  logic signed [SW-1:0]   sum_c;
  logic signed [AW-1:0]   rnd_c;
  logic signed [AW-1:0]   shf_c;
  logic [DW-1:0]          res_c;

  // Each slot loads when it is empty or its occupant moves on this cycle.
  always_comb begin
    ld3_c = out_ready || !out_valid;
    ld2_c = !s2_valid || ld3_c;
    ld1_c = !s1_valid || ld2_c;
  end

  assign in_ready = !rst && ld1_c;
  assign in_acc_c = in_valid && in_ready;

  // S1: unsigned pixel times signed coefficient, per tap.
  always_comb begin
    logic signed [PW-1:0] px;
    logic signed [PW-1:0] kc;
    prod_c = '0;
    px     = '0;
    kc     = '0;
    for (int i = 0; i < N; i++) begin
      px = PW'($signed({1'b0, din[i*DW +: DW]}));
      kc = PW'($signed(kernel[i*KWIDTH +: KWIDTH]));
      prod_c[i*PW +: PW] = px * kc;
    end
  end

  conv_adder_tree #(
    .N  (N),
    .PW (PW)
  ) u_tree (
    .prods (s1_prod),
    .sum_c (sum_c)
  );

  // S3: round half up, arithmetic shift, optional ReLU, saturate.
  always_comb begin
    rnd_c = AW'(s2_sum) + RND;
    shf_c = rnd_c >>> SHIFT;
`ifdef CONV_MAC_RELU_EN
    if (shf_c < 0) shf_c = '0;
`endif
    res_c = DW'(sat_signed(64'(shf_c), DW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kernel    <= '0;
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_sum    <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (k_load) kernel <= k_data;
      if (ld1_c) s1_valid <= in_acc_c;
      if (in_acc_c) s1_prod <= prod_c;
      if (ld2_c) s2_valid <= s1_valid;
      if (ld2_c && s1_valid) s2_sum <= sum_c;
      if (ld3_c) out_valid <= s2_valid;
      if (ld3_c && s2_valid) dout <= res_c;
    end
  end

endmodule
